// File: rtl/pe_window_feeder.sv
// pe_window_feeder
//
// Sits in front of the 1-D convolution PE. It takes a serial stream of 2-bit
// activations and builds overlapping 5-element windows with a stride of 3.
// Consecutive windows share 2 elements, so the PE's 3 outputs per window cover
// the row with no gaps. The filter word is captured only while idle, so one
// filter is used for a whole row.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   filt_in    filter taps {f2,f1,f0}, f0 at [1:0]
//   filt_load  capture filt_in (only honoured in IDLE)
//   act_in     activation element
//   act_valid  act_in is valid
//   act_ready  feeder accepts act_in this cycle (depends on state only)
//   win_out    window {e4,e3,e2,e1,e0}, e0 (oldest) at [1:0]
//   filt_out   registered filter word
//   win_valid  win_out is valid; held until win_ready
//   win_ready  downstream consumes the window
//   win_last   final window of the row
//   row_done   one-cycle pulse after the final window handshake
module pe_window_feeder #(
    parameter int NWIN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] filt_in,
    input  logic       filt_load,
    input  logic [1:0] act_in,
    input  logic       act_valid,
    output logic       act_ready,
    output logic [9:0] win_out,
    output logic [5:0] filt_out,
    output logic       win_valid,
    input  logic       win_ready,
    output logic       win_last,
    output logic       row_done
);

    localparam int WW = (NWIN > 1) ? $clog2(NWIN) : 1;
    localparam logic [WW-1:0] WIDX_LAST = WW'(NWIN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [2:0]    cnt_reg, cnt_next;
    logic [WW-1:0] widx_reg, widx_next;
    logic [5:0]    filt_reg, filt_next;
    logic          row_done_reg, row_done_next;
    logic [9:0]    win_reg, win_next;
    logic          act_fire;
    logic          shift_en;

    assign act_fire = act_valid && act_ready;

    // Slot update: an accepted element lands in slot cnt. When a window is
    // handed off mid-row, the two newest elements (e3,e4) become the two
    // oldest (e0,e1) of the next window; slots 2..4 are refilled from the
    // stream.
    for (genvar gi = 0; gi < 5; gi++) begin : g_slot
        if (gi < 2) begin : g_keep
            assign win_next[2*gi +: 2] =
                (act_fire && cnt_reg == 3'(gi)) ? act_in :
                shift_en                        ? win_reg[2*(gi+3) +: 2] :
                                                  win_reg[2*gi +: 2];
        end else begin : g_new
            assign win_next[2*gi +: 2] =
                (act_fire && cnt_reg == 3'(gi)) ? act_in : win_reg[2*gi +: 2];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            widx_reg     <= '0;
            filt_reg     <= '0;
            row_done_reg <= 1'b0;
            win_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            widx_reg     <= widx_next;
            filt_reg     <= filt_next;
            row_done_reg <= row_done_next;
            win_reg      <= win_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        widx_next     = widx_reg;
        filt_next     = filt_reg;
        row_done_next = 1'b0;
        act_ready     = 1'b0;
        win_valid     = 1'b0;
        shift_en      = 1'b0;
        case (state_reg)
            IDLE: begin
                act_ready = 1'b1;
                if (filt_load) begin
                    filt_next = filt_in;
                end
                if (act_valid) begin
                    cnt_next   = 3'd1;
                    state_next = FILL;
                end
            end
            FILL: begin
                act_ready = 1'b1;
                if (act_valid) begin
                    cnt_next = cnt_reg + 3'd1;
                    if (cnt_reg == 3'd4) begin
                        state_next = EMIT;
                    end
                end
            end
            EMIT: begin
                win_valid = 1'b1;
                if (win_ready) begin
                    if (widx_reg == WIDX_LAST) begin
                        cnt_next      = 3'd0;
                        widx_next     = '0;
                        row_done_next = 1'b1;
                        state_next    = IDLE;
                    end else begin
                        shift_en   = 1'b1;
                        cnt_next   = 3'd2;
                        widx_next  = widx_reg + WW'(1);
                        state_next = FILL;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign win_out  = win_reg;
    assign filt_out = filt_reg;
    assign win_last = win_valid && (widx_reg == WIDX_LAST);
    assign row_done = row_done_reg;

endmodule
